// File: rtl/dffx_pkg.sv
// Shared flip-flop-path package: common widths and the deserializer state type.
package dffx;

    localparam int unsigned dff_bits_count = 8;

    localparam int unsigned DESER_DEFAULT_BITS = dff_bits_count;

    typedef enum logic [0:0] {
        SHIFTING,
        WORD_HELD
    } deser_state_t;

endpackage

// File: rtl/serial_deserializer_if.sv
// Serial input and parallel valid/ready output bundle of the deserializer.
interface serial_deserializer_if #(
    parameter int unsigned BITS_COUNT = dffx::DESER_DEFAULT_BITS
);
    logic                  sin;
    logic                  sin_valid;
    logic                  sin_ready;
    logic                  sync;
    logic [BITS_COUNT-1:0] pout;
    logic                  pout_valid;
    logic                  pout_ready;
    logic                  align_err;

    modport master (
        output sin, sin_valid, sync, pout_ready,
        input  sin_ready, pout, pout_valid, align_err
    );

    modport slave (
        input  sin, sin_valid, sync, pout_ready,
        output sin_ready, pout, pout_valid, align_err
    );
endinterface

// File: rtl/word_hold_reg.sv
// One-entry valid/ready holding register; its state is exactly the output valid flag.
module word_hold_reg
    import dffx::*;
#(
    parameter int unsigned WIDTH = DESER_DEFAULT_BITS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ready,
    output logic [WIDTH-1:0] data,
    output logic             valid
);

    deser_state_t     state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;

    // The producer never loads while held and not drained, so that case is absent.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        unique case (state_q)
            SHIFTING: begin
                if (load) begin
                    state_d = WORD_HELD;
                    data_d  = load_data;
                end
            end
            WORD_HELD: begin
                if (ready) begin
                    if (load) begin
                        data_d = load_data;
                    end else begin
                        state_d = SHIFTING;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SHIFTING;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    assign data  = data_q;
    assign valid = (state_q == WORD_HELD);

endmodule

// File: rtl/serial_deserializer.sv
// Serial-in, parallel-out receiver with word-boundary sync and a one-entry output hold.
module serial_deserializer
    import dffx::*;
#(
    parameter int unsigned BITS_COUNT = DESER_DEFAULT_BITS,
    parameter bit          MSB_FIRST  = 1'b1
) (
    input logic                   clk,
    input logic                   rst,
    serial_deserializer_if.slave  bus
);

    localparam int unsigned CntW = $clog2(BITS_COUNT);
    localparam logic [CntW-1:0] LastCnt = CntW'(BITS_COUNT - 1);

    logic [BITS_COUNT-1:0] shift_q, shift_d;
    logic [BITS_COUNT-1:0] word;
    logic [BITS_COUNT-1:0] first_bit_word;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  align_err_q, align_err_d;
    logic                  accept;
    logic                  word_done;

    // Only the final bit of a word can stall: it needs a free holding slot.
    assign bus.sin_ready = !((cnt_q == LastCnt) && bus.pout_valid && !bus.pout_ready);
    assign accept        = bus.sin_valid && bus.sin_ready;
    assign word_done     = accept && !bus.sync && (cnt_q == LastCnt);

    assign word = MSB_FIRST ? {shift_q[BITS_COUNT-2:0], bus.sin}
                            : {bus.sin, shift_q[BITS_COUNT-1:1]};
    assign first_bit_word = MSB_FIRST ? {{(BITS_COUNT-1){1'b0}}, bus.sin}
                                      : {bus.sin, {(BITS_COUNT-1){1'b0}}};

    always_comb begin
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        align_err_d = bus.sync && (cnt_q != '0);
        if (bus.sync) begin
            shift_d = '0;
            cnt_d   = '0;
            if (accept) begin
                shift_d = first_bit_word;
                cnt_d   = CntW'(1);
            end
        end else if (accept) begin
            shift_d = word;
            cnt_d   = (cnt_q == LastCnt) ? '0 : cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q     <= '0;
            cnt_q       <= '0;
            align_err_q <= 1'b0;
        end else begin
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            align_err_q <= align_err_d;
        end
    end

    assign bus.align_err = align_err_q;

    word_hold_reg #(
        .WIDTH (BITS_COUNT)
    ) u_hold (
        .clk       (clk),
        .rst       (rst),
        .load      (word_done),
        .load_data (word),
        .ready     (bus.pout_ready),
        .data      (bus.pout),
        .valid     (bus.pout_valid)
    );

endmodule

// File: tb/tb_serial_deserializer.sv
// Directed bench: MSB-first and LSB-first instances driven with hand-computed words.
module tb_serial_deserializer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    serial_deserializer_if #(.BITS_COUNT(8)) bus_m ();
    serial_deserializer_if #(.BITS_COUNT(8)) bus_l ();

    serial_deserializer #(.BITS_COUNT(8), .MSB_FIRST(1'b1)) u_dut_m (
        .clk (clk),
        .rst (rst),
        .bus (bus_m.slave)
    );

    serial_deserializer #(.BITS_COUNT(8), .MSB_FIRST(1'b0)) u_dut_l (
        .clk (clk),
        .rst (rst),
        .bus (bus_l.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one bit on the MSB-first instance for one edge.
    task automatic bit_m(input logic b);
        bus_m.sin       = b;
        bus_m.sin_valid = 1'b1;
        tick();
        bus_m.sin_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst             = 1'b1;
        bus_m.sin_valid = 1'b1;
        bus_m.sin       = 1'b1;
        tick();
        tick();
        rst             = 1'b0;
        bus_m.sin_valid = 1'b0;
        #1;
        checks++;
        if (bus_m.pout_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid got %b want 0", bus_m.pout_valid);
        end
        checks++;
        if (bus_m.pout !== 8'h00) begin
            errors++; $display("FAIL reset_pout got %h want 00", bus_m.pout);
        end
        checks++;
        if (bus_m.align_err !== 1'b0) begin
            errors++; $display("FAIL reset_align got %b want 0", bus_m.align_err);
        end
        checks++;
        if (bus_m.sin_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready got %b want 1", bus_m.sin_ready);
        end
        checks++;
        if (bus_l.pout !== 8'h00 || bus_l.pout_valid !== 1'b0) begin
            errors++; $display("FAIL reset_lsb got %h/%b want 00/0", bus_l.pout, bus_l.pout_valid);
        end
        tick();
    endtask

    task automatic test_msb_first();
        logic [7:0] w = 8'hA5;
        int early = 0;
        bus_m.pout_ready = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            bit_m(w[i]);
            if (i != 0 && bus_m.pout_valid !== 1'b0) early++;
        end
        checks++;
        if (early != 0) begin
            errors++; $display("FAIL msb_early_valid got %0d want 0", early);
        end
        checks++;
        if (bus_m.pout_valid !== 1'b1 || bus_m.pout !== 8'hA5) begin
            errors++; $display("FAIL msb_word got %h/%b want a5/1", bus_m.pout, bus_m.pout_valid);
        end
        tick();
        checks++;
        if (bus_m.pout_valid !== 1'b0) begin
            errors++; $display("FAIL msb_one_cycle got %b want 0", bus_m.pout_valid);
        end
    endtask

    task automatic test_lsb_first();
        logic [7:0] bits = 8'b1111_1000;
        bus_l.pout_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus_l.sin       = bits[i];
            bus_l.sin_valid = 1'b1;
            tick();
        end
        bus_l.sin_valid = 1'b0;
        checks++;
        if (bus_l.pout_valid !== 1'b1 || bus_l.pout !== 8'hF8) begin
            errors++; $display("FAIL lsb_word got %h/%b want f8/1", bus_l.pout, bus_l.pout_valid);
        end
        tick();
    endtask

    task automatic test_backpressure();
        logic [7:0] a = 8'h3C;
        logic [7:0] b = 8'h81;
        int unstable = 0;
        bus_m.pout_ready = 1'b0;
        for (int i = 7; i >= 0; i--) bit_m(a[i]);
        checks++;
        if (bus_m.pout_valid !== 1'b1 || bus_m.pout !== 8'h3C) begin
            errors++; $display("FAIL bp_first got %h/%b want 3c/1", bus_m.pout, bus_m.pout_valid);
        end
        for (int i = 7; i >= 1; i--) begin
            bit_m(b[i]);
            if (bus_m.pout !== 8'h3C || bus_m.pout_valid !== 1'b1) unstable++;
        end
        checks++;
        if (unstable != 0) begin
            errors++; $display("FAIL bp_stable got %0d changes want 0", unstable);
        end
        bus_m.sin       = b[0];
        bus_m.sin_valid = 1'b1;
        #1;
        checks++;
        if (bus_m.sin_ready !== 1'b0) begin
            errors++; $display("FAIL bp_stall got %b want 0", bus_m.sin_ready);
        end
        tick();
        tick();
        checks++;
        if (bus_m.pout !== 8'h3C || bus_m.sin_ready !== 1'b0) begin
            errors++; $display("FAIL bp_hold got %h/%b want 3c/0", bus_m.pout, bus_m.sin_ready);
        end
        bus_m.pout_ready = 1'b1;
        #1;
        checks++;
        if (bus_m.sin_ready !== 1'b1 || bus_m.pout !== 8'h3C) begin
            errors++; $display("FAIL bp_release got %b/%h want 1/3c", bus_m.sin_ready, bus_m.pout);
        end
        tick();
        bus_m.sin_valid = 1'b0;
        checks++;
        if (bus_m.pout_valid !== 1'b1 || bus_m.pout !== 8'h81) begin
            errors++; $display("FAIL bp_second got %h/%b want 81/1", bus_m.pout, bus_m.pout_valid);
        end
        tick();
        checks++;
        if (bus_m.pout_valid !== 1'b0) begin
            errors++; $display("FAIL bp_drain got %b want 0", bus_m.pout_valid);
        end
    endtask

    task automatic test_sync();
        logic [7:0] w = 8'h5A;
        bus_m.pout_ready = 1'b1;
        bit_m(1'b1);
        bit_m(1'b1);
        bit_m(1'b1);
        bus_m.sync = 1'b1;
        bit_m(w[7]);
        bus_m.sync = 1'b0;
        checks++;
        if (bus_m.align_err !== 1'b1) begin
            errors++; $display("FAIL sync_err_pulse got %b want 1", bus_m.align_err);
        end
        bit_m(w[6]);
        checks++;
        if (bus_m.align_err !== 1'b0) begin
            errors++; $display("FAIL sync_err_width got %b want 0", bus_m.align_err);
        end
        for (int i = 5; i >= 0; i--) bit_m(w[i]);
        checks++;
        if (bus_m.pout_valid !== 1'b1 || bus_m.pout !== 8'h5A) begin
            errors++; $display("FAIL sync_word got %h/%b want 5a/1", bus_m.pout, bus_m.pout_valid);
        end
        bus_m.sync = 1'b1;
        tick();
        bus_m.sync = 1'b0;
        checks++;
        if (bus_m.align_err !== 1'b0) begin
            errors++; $display("FAIL sync_boundary got %b want 0", bus_m.align_err);
        end
        tick();
    endtask

    task automatic test_mid_reset();
        logic [7:0] w = 8'h96;
        int early = 0;
        bus_m.pout_ready = 1'b0;
        for (int i = 0; i < 8; i++) bit_m(1'b1);
        bit_m(1'b1);
        bit_m(1'b0);
        bit_m(1'b1);
        bit_m(1'b0);
        checks++;
        if (bus_m.pout_valid !== 1'b1 || bus_m.pout !== 8'hFF) begin
            errors++; $display("FAIL mid_pre got %h/%b want ff/1", bus_m.pout, bus_m.pout_valid);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (bus_m.pout_valid !== 1'b0 || bus_m.pout !== 8'h00 || bus_m.align_err !== 1'b0
            || bus_m.sin_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset got %h/%b/%b/%b want 00/0/0/1", bus_m.pout,
                     bus_m.pout_valid, bus_m.align_err, bus_m.sin_ready);
        end
        bus_m.pout_ready = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            bit_m(w[i]);
            if (i != 0 && bus_m.pout_valid !== 1'b0) early++;
        end
        checks++;
        if (early != 0) begin
            errors++; $display("FAIL mid_early_valid got %0d want 0", early);
        end
        checks++;
        if (bus_m.pout_valid !== 1'b1 || bus_m.pout !== 8'h96) begin
            errors++; $display("FAIL mid_word got %h/%b want 96/1", bus_m.pout, bus_m.pout_valid);
        end
        tick();
    endtask

    initial begin
        bus_m.sin        = 1'b0;
        bus_m.sin_valid  = 1'b0;
        bus_m.sync       = 1'b0;
        bus_m.pout_ready = 1'b1;
        bus_l.sin        = 1'b0;
        bus_l.sin_valid  = 1'b0;
        bus_l.sync       = 1'b0;
        bus_l.pout_ready = 1'b1;
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_backpressure();
        test_sync();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_deserializer.md
Name: serial_deserializer

Overview:
- Serial-in, parallel-out receiver. It collects a 1-bit stream into BITS_COUNT-wide words and presents each word on a valid/ready output.
- It is the receiving end for the parallel-to-serial path that feeds the register bank from the registered-data side.
- A one-entry holding register lets shifting continue while the consumer stalls.
- A sync input aligns word boundaries.

Parameters:
- BITS_COUNT, 8, word width in bits; legal range is 2 or more.
- MSB_FIRST, 1, when 1 the first received bit lands in pout[BITS_COUNT-1]; when 0 it lands in pout[0].

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- sin  input  1  serial data bit.
- sin_valid  input  1  sin carries a bit this cycle.
- sin_ready  output  1  block accepts a bit this cycle.
- sync  input  1  start-of-word marker; restarts alignment.
- pout  output  BITS_COUNT  assembled word.
- pout_valid  output  1  pout holds a complete word.
- pout_ready  input  1  consumer takes pout this cycle.
- align_err  output  1  one-cycle pulse: sync arrived while a partial word was held.

Behaviour:
- Reset (rst high at a clk edge):
  - Clears bit_cnt, the shift register, the holding register, pout_valid and align_err.
  - pout reads 0.
  - rst overrides all other inputs in the same cycle, including mid-word and with pout_valid high. The partial word and the held word are discarded.
- Bit accept: a bit is accepted when sin_valid && sin_ready at the edge.
- Counter: bit_cnt counts 0..BITS_COUNT-1. Width is $clog2(BITS_COUNT). It wraps to 0 after the last bit.
- Shift direction:
  - MSB_FIRST=1: shift left, new bit enters at the LSB.
  - MSB_FIRST=0: shift right, new bit enters at the MSB.
- States: SHIFTING and WORD_HELD.
  - The FSM tracks only pout_valid; bit_cnt runs independently.
  - SHIFTING -> WORD_HELD: when the last bit is accepted.
  - WORD_HELD -> SHIFTING: when pout_ready is high and no new word completes that cycle.
  - WORD_HELD -> WORD_HELD (new content): when pout_ready is high and a new word completes in the same cycle (back-to-back).
- Latency: pout_valid rises at the edge that accepts the last bit. It is visible the cycle after the last bit is presented.
- Holding behaviour: pout and pout_valid are registered. pout stays stable while pout_valid && !pout_ready.
- Backpressure:
  - sin_ready = !(bit_cnt==BITS_COUNT-1 && pout_valid && !pout_ready). This is combinational from registered state plus pout_ready.
  - No bit and no word is ever dropped or overwritten.
  - Bits 0..BITS_COUNT-2 of the next word are accepted during a stall.
- sync:
  - When high at an edge, the partial word is discarded and bit_cnt is forced to 0.
  - If a bit is also accepted in that cycle, that bit becomes bit 0 of the new word, and bit_cnt becomes 1.
  - align_err pulses in the next cycle if bit_cnt!=0 before the sync. No pulse if sync lands exactly on a boundary.
  - sync does not affect the holding register.
- Bits presented while sin_valid=0 are ignored; there is no timeout.

Decomposition:
- Package dffx gains:
  - deser_state_t, the enum {SHIFTING, WORD_HELD}.
  - Constant DESER_DEFAULT_BITS = dffx::dff_bits_count.
- One sub-module, word_hold_reg: the one-entry valid/ready holding register, parameterised by width. It contains the load/drain logic and the pout_valid state.
- The shifter, bit counter, sync and align_err logic stay in the top.

Test Plan:
All cases use BITS_COUNT=8.
1. Reset: hold rst high 2 cycles with sin_valid=1 -> pout_valid=0, pout=8'h00, align_err=0, sin_ready=1 after release.
2. MSB_FIRST=1, pout_ready=1, bits 1,0,1,0,0,1,0,1 back-to-back -> pout=8'hA5, with pout_valid high exactly one cycle, the cycle after bit 8.
3. MSB_FIRST=0, bits 0,0,0,1,1,1,1,1 -> pout=8'hF8.
4. Backpressure, pout_ready=0, send 8'h3C then 8'h81:
   - pout=8'h3C stays stable.
   - sin_ready drops while bit 8 of 8'h81 is presented.
   - Raise pout_ready -> 8'h3C handed off; 8'h81 valid the next cycle; no bits lost.
5. Send 3 bits, then sync together with the first bit of 8'h5A -> align_err pulses for 1 cycle and pout=8'h5A. A second sync on a word boundary gives no pulse.
6. Mid-operation reset: pout_valid=1 with 8'hFF held and 4 bits of the next word in; assert rst 1 cycle -> everything cleared. The next 8 bits give a correct word (e.g. 8'h96).
